// File: rtl/led_scan_mux.sv
// Time-multiplexed driver for multi-digit LED / 7-segment displays.
// Scans one digit per slot with PWM brightness, per-digit blanking and a frame-start strobe.
module led_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SEG_W          = 8,
  parameter int unsigned PRESCALE       = 1024,
  parameter int unsigned BRIGHT_W       = 3,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  input  logic                        scan_en,
  output logic [NUM_DIGITS-1:0]       LEDSEL,
  output logic [SEG_W-1:0]            LEDOUT,
  output logic                        frame_start
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0]       CntMax   = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0]       IdxMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0]   PhaseMax = '1;
  localparam logic [NUM_DIGITS-1:0] SelIdle  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SegIdle  = {SEG_W{SEG_ACTIVE_LOW}};

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BRIGHT_W-1:0]   phase_q, phase_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_DIGITS-1:0] ledsel_q, ledsel_d;
  logic [SEG_W-1:0]      ledout_q, ledout_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic [SEG_W-1:0]      seg_sel;
  logic                  en_sel;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  lit;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    tick    = (cnt_q == CntMax);
    if (!scan_en) begin
      cnt_d   = '0;
      phase_d = '0;
      idx_d   = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      if (tick) begin
        phase_d = phase_q + BRIGHT_W'(1);
        if (phase_q == PhaseMax) begin
          // Explicit wrap so non-power-of-2 digit counts work.
          idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
        end
      end
    end
  end

  always_comb begin
    seg_sel = '0;
    en_sel  = 1'b0;
    onehot  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        seg_sel   = digits[i*SEG_W +: SEG_W];
        en_sel    = digit_en[i];
        onehot[i] = 1'b1;
      end
    end
    // Top brightness code still leaves the last phase dark: inter-digit dead time.
    lit      = scan_en & en_sel & (phase_q < brightness);
    ledsel_d = lit ? (onehot ^ SelIdle) : SelIdle;
    ledout_d = lit ? seg_sel : SegIdle;
    frame_d  = scan_en & (cnt_q == '0) & (phase_q == '0) & (idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      ledsel_q <= SelIdle;
      ledout_q <= SegIdle;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      ledsel_q <= ledsel_d;
      ledout_q <= ledout_d;
      frame_q  <= frame_d;
    end
  end

  assign LEDSEL      = ledsel_q;
  assign LEDOUT      = ledout_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux: 4-digit and 6-digit instances run side by side.
module tb_led_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] digits4;
  logic [47:0] digits6;
  logic [3:0]  en4;
  logic [5:0]  en6;
  logic [1:0]  bright;
  logic        scan_en;
  logic [3:0]  sel4;
  logic [7:0]  out4;
  logic        fs4;
  logic [5:0]  sel6;
  logic [7:0]  out6;
  logic        fs6;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 clk = ~clk;

  led_scan_mux #(
    .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(2), .BRIGHT_W(2),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .digits(digits4), .digit_en(en4), .brightness(bright),
    .scan_en(scan_en), .LEDSEL(sel4), .LEDOUT(out4), .frame_start(fs4)
  );

  led_scan_mux #(
    .NUM_DIGITS(6), .SEG_W(8), .PRESCALE(2), .BRIGHT_W(2),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .digits(digits6), .digit_en(en6), .brightness(bright),
    .scan_en(scan_en), .LEDSEL(sel6), .LEDOUT(out6), .frame_start(fs6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_sel4"}, 32'(sel4), 32'h0000_000F);
    chk({tag, "_out4"}, 32'(out4), 32'h0000_00FF);
    chk({tag, "_fs4"},  32'(fs4),  32'h0);
    chk({tag, "_sel6"}, 32'(sel6), 32'h0000_003F);
    chk({tag, "_out6"}, 32'(out6), 32'h0000_00FF);
    chk({tag, "_fs6"},  32'(fs6),  32'h0);
  endtask

  // Output k cycles after scan start: slot = 8 clks, phase = 2 clks.
  task automatic scan_step();
    int         i4, i6, ph;
    logic       lit4, lit6;
    logic [3:0] es4;
    logic [5:0] es6;
    logic [7:0] eo4, eo6;
    @(negedge clk);
    ph   = (k / 2) % 4;
    i4   = (k / 8) % 4;
    i6   = (k / 8) % 6;
    lit4 = en4[i4] && (ph < int'(bright));
    lit6 = en6[i6] && (ph < int'(bright));
    es4  = lit4 ? ~(4'b0001 << i4) : 4'hF;
    es6  = lit6 ? ~(6'b000001 << i6) : 6'h3F;
    eo4  = lit4 ? 8'((i4 + 1) * 17) : 8'hFF;
    eo6  = lit6 ? 8'((i6 + 1) * 17) : 8'hFF;
    chk("sel4", 32'(sel4), 32'(es4));
    chk("out4", 32'(out4), 32'(eo4));
    chk("fs4",  32'(fs4),  32'((k % 32) == 0));
    chk("sel6", 32'(sel6), 32'(es6));
    chk("out6", 32'(out6), 32'(eo6));
    chk("fs6",  32'(fs6),  32'((k % 48) == 0));
    chk("onehot4", 32'($countones(~sel4) <= 1), 32'h1);
    chk("onehot6", 32'($countones(~sel6) <= 1), 32'h1);
    k++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    digits4 = {8'h44, 8'h33, 8'h22, 8'h11};
    digits6 = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    en4     = 4'hF;
    en6     = 6'h3F;
    bright  = 2'd3;
    scan_en = 1'b1;

    repeat (3) @(negedge clk);
    chk_blank("reset");

    rst_n = 1'b1;
    k     = 0;
    for (int n = 0; n < 160; n++) begin
      if (n == 64)  bright = 2'd1;
      if (n == 96)  bright = 2'd0;
      if (n == 128) begin
        bright = 2'd3;
        en4    = 4'b1011;
      end
      scan_step();
    end

    en4 = 4'hF;
    for (int n = 0; n < 20; n++) scan_step();
    // Last output checked was mid-slot 2; stop scanning here.
    scan_en = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk_blank("scan_off");
    end

    scan_en = 1'b1;
    k       = 0;
    for (int n = 0; n < 20; n++) scan_step();

    #2 rst_n = 1'b0;
    #1 chk_blank("async_rst");
    repeat (2) @(negedge clk);
    chk_blank("rst_hold");

    rst_n = 1'b1;
    k     = 0;
    for (int n = 0; n < 50; n++) scan_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_mux.md
Name: led_scan_mux

Overview:
Parametrised time-multiplexed driver for common-select multi-digit LED or 7-segment displays. It scans NUM_DIGITS segment words onto a single shared segment bus with one-hot digit selects. It adds a programmable scan rate, per-digit blanking, PWM brightness control, a guaranteed inter-digit dead time against ghosting, a scan enable, and a frame-start strobe. It sits between the display-data registers and the board LED/segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2, need not be a power of 2)
SEG_W, 8, segment bits per digit
PRESCALE, 1024, clk cycles per scan tick (>=1)
BRIGHT_W, 3, brightness width; a digit slot is 2^BRIGHT_W ticks
SEL_ACTIVE_LOW, 1, 1 = LEDSEL active-low; 0 = active-high
SEG_ACTIVE_LOW, 1, 1 = blank LEDOUT is all-ones; 0 = blank is all-zeros

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits  in  NUM_DIGITS*SEG_W  packed segment words; digit i = digits[i*SEG_W +: SEG_W]
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit always blanked
brightness  in  BRIGHT_W  on-ticks per slot; 0 = dark
scan_en  in  1  1 = scanning; 0 = display blanked and scan held at start
LEDSEL  out  NUM_DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW
LEDOUT  out  SEG_W  segment data for the selected digit
frame_start  out  1  one-clk pulse at the start of slot 0

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0, idx=0, phase=0; LEDSEL all inactive; LEDOUT blank; frame_start=0. All outputs are registered and reach these values immediately, without waiting for a clock edge.
- Prescaler counts 0..PRESCALE-1. A tick is the cycle in which it equals PRESCALE-1; the counter wraps to 0 on that cycle. With PRESCALE=1, every cycle is a tick.
- On a tick, phase increments modulo 2^BRIGHT_W. When phase wraps, idx increments. idx wraps from NUM_DIGITS-1 to 0, with an explicit compare for non-power-of-2 counts.
- Timing: phase = PRESCALE clks; slot = PRESCALE*2^BRIGHT_W clks; frame = NUM_DIGITS*slot clks.
- Digit idx is lit when all of the following hold: scan_en=1, digit_en[idx]=1, and phase < brightness.
  - Lit: LEDSEL asserts only bit idx; LEDOUT = digits word idx.
  - Otherwise: LEDSEL is all inactive and LEDOUT is blank.
- Maximum brightness (2^BRIGHT_W - 1) always leaves one dark tick at the end of every slot. This is the inter-digit dead time and must never be zero.
- Registered outputs are computed from the current idx, phase and inputs, giving one clk of latency from any input or state change to the pins.
- brightness, digit_en and digits are sampled every clk and have no slot-boundary latching.
- LEDSEL never has more than one bit active in any cycle.
- frame_start is a registered 1-clk pulse, coincident with the first output cycle of idx=0, phase=0. It is produced:
  - after every idx wrap;
  - on the first scanning cycle after reset release;
  - on the first scanning cycle after a scan_en rise.
  - It pulses even when digit 0 is blanked or brightness=0.
- scan_en=0: prescaler, idx and phase are held at 0, and outputs are blanked from the next clk. On re-assertion, scanning restarts at slot 0, phase 0.
- Reset asserted mid-slot aborts the slot. Scanning resumes from digit 0 after release.

Test Plan:
(Parameters unless stated: NUM_DIGITS=4, SEG_W=8, PRESCALE=2, BRIGHT_W=2, active-low both.)
- Reset: hold rst_n=0 with digits driven -> LEDSEL=4'b1111, LEDOUT=8'hFF, frame_start=0. Assert rst_n=0 asynchronously mid-slot 2 -> outputs blank before the next clk edge.
- Full brightness (brightness=3, digits={8'h44,8'h33,8'h22,8'h11}, digit_en=4'hF) -> per slot: 6 clks of lit output then 2 clks of 1111/FF. Lit outputs in order: 1110/11, 1101/22, 1011/33, 0111/44. frame_start pulses every 32 clks.
- Brightness sweep: brightness=1 -> 2 lit clks per 8-clk slot. brightness=0 -> LEDSEL stays 1111 throughout, while frame_start still pulses every 32 clks.
- Blanking: digit_en=4'b1011 -> slot 2 is fully dark (1111/FF for 8 clks); slots 0, 1 and 3 are unchanged.
- Non-power-of-2 count: NUM_DIGITS=6 -> idx sequence 0..5,0; frame = 48 clks; LEDSEL=6'b011111 in slot 5; never more than one select low.
- scan_en: drop scan_en mid-slot 2 -> outputs blank on the next clk. Raise it again -> slot 0 phase 0 appears with a frame_start pulse.
